// File: rtl/timer_ctrl_pkg.sv
// Shared widths, compare-flag record and stage-1 compare helper for the machine timer.
package timer_ctrl_pkg;

    localparam int MTIME_W = 64;
    localparam int HALF_W  = 32;
    localparam int PS_W    = 16;

    localparam logic [HALF_W-1:0] HALF_MAX = {HALF_W{1'b1}};

    typedef struct packed {
        logic hi_gt;
        logic hi_eq;
        logic lo_ge;
    } cmp_flags_t;

    // Split 64-bit unsigned compare into half-width flags so each stage stays shallow.
    function automatic cmp_flags_t cmp_stage1(
        input logic [MTIME_W-1:0] cur,
        input logic [MTIME_W-1:0] cmp
    );
        cmp_flags_t f;
        f.hi_gt = (cur[MTIME_W-1:HALF_W] >  cmp[MTIME_W-1:HALF_W]);
        f.hi_eq = (cur[MTIME_W-1:HALF_W] == cmp[MTIME_W-1:HALF_W]);
        f.lo_ge = (cur[HALF_W-1:0]       >= cmp[HALF_W-1:0]);
        return f;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the machine timer: divides run cycles by PRESCALE and flags each increment.
module timer_prescaler
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic inc
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt_q;
    logic [PS_W-1:0] ps_cnt_d;
    logic            at_last_s;

    assign at_last_s = (ps_cnt_q == PS_LAST);
    // The increment must land on the same edge as the wrap, so it is decoded, not registered.
    assign inc       = run & at_last_s;

    // Next prescale count: holds whenever run is low so halt/en never lose phase.
    always_comb begin
        ps_cnt_d = ps_cnt_q;
        if (clr) begin
            ps_cnt_d = '0;
        end else if (run) begin
            if (at_last_s) begin
                ps_cnt_d = '0;
            end else begin
                ps_cnt_d = ps_cnt_q + 16'd1;
            end
        end else begin
            ps_cnt_d = ps_cnt_q;
        end
    end

    // Prescale count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Machine timer: prescaled split 64-bit mtime with coherent snapshot, pipelined
// mtimecmp compare driving mtip, and registered software interrupt.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               halt,
    input  logic               clr,
    input  logic [MTIME_W-1:0] mtimecmp,
    input  logic [31:0]        msip,
    output logic [MTIME_W-1:0] mtime,
    output logic               tick,
    output logic               mtip,
    output logic               msip_irq
);

    logic               run_s;
    logic               inc_s;
    logic               lo_max_s;
    logic               unused_msip_s;

    logic [HALF_W-1:0]  lo_q;
    logic [HALF_W-1:0]  lo_d;
    logic [HALF_W-1:0]  hi_q;
    logic [HALF_W-1:0]  hi_d;
    logic               carry_pend_q;
    logic               carry_pend_d;
    logic [MTIME_W-1:0] mtime_q;
    logic [MTIME_W-1:0] mtime_d;
    logic               tick_q;
    cmp_flags_t         flags_q;
    logic               mtip_q;
    logic               msip_irq_q;

    assign run_s         = en & ~halt & ~clr;
    assign lo_max_s      = (lo_q == HALF_MAX);
    assign unused_msip_s = ^msip[31:1];

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_s),
        .clr   (clr),
        .inc   (inc_s)
    );

    // Counter halves and snapshot; the snapshot skips the one cycle where hi lags a lo wrap.
    always_comb begin
        lo_d         = lo_q;
        hi_d         = hi_q;
        carry_pend_d = carry_pend_q;
        mtime_d      = mtime_q;
        if (clr) begin
            lo_d         = '0;
            hi_d         = '0;
            carry_pend_d = 1'b0;
            mtime_d      = '0;
        end else begin
            if (inc_s) begin
                lo_d = lo_q + 32'd1;
            end else begin
                lo_d = lo_q;
            end
            if (carry_pend_q) begin
                hi_d = hi_q + 32'd1;
            end else begin
                hi_d = hi_q;
            end
            carry_pend_d = inc_s & lo_max_s;
            if (!carry_pend_q) begin
                mtime_d = {hi_q, lo_q};
            end else begin
                mtime_d = mtime_q;
            end
        end
    end

    // State registers, tick, compare pipeline and software interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_q         <= '0;
            hi_q         <= '0;
            carry_pend_q <= 1'b0;
            mtime_q      <= '0;
            tick_q       <= 1'b0;
            flags_q      <= '0;
            mtip_q       <= 1'b0;
            msip_irq_q   <= 1'b0;
        end else begin
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            carry_pend_q <= carry_pend_d;
            mtime_q      <= mtime_d;
            tick_q       <= inc_s;
            flags_q      <= cmp_stage1(mtime_q, mtimecmp);
            mtip_q       <= flags_q.hi_gt | (flags_q.hi_eq & flags_q.lo_ge);
            msip_irq_q   <= msip[0];
        end
    end

    assign mtime    = mtime_q;
    assign tick     = tick_q;
    assign mtip     = mtip_q;
    assign msip_irq = msip_irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: three instances (PRESCALE 1, 4, 8) on shared stimulus.
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        halt;
    logic        clr;
    logic [63:0] mtimecmp;
    logic [31:0] msip;

    logic [63:0] m1, m4, m8;
    logic        t1, t4, t8;
    logic        p1, p4, p8;
    logic        i1, i4, i8;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] carry_seq [5] = '{64'h0000_0000_FFFF_FFFE, 64'h0000_0000_FFFF_FFFF,
                                   64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0001,
                                   64'h0000_0001_0000_0002};

    always #5 clk = ~clk;

    timer_ctrl #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .halt(halt), .clr(clr),
        .mtimecmp(mtimecmp), .msip(msip),
        .mtime(m1), .tick(t1), .mtip(p1), .msip_irq(i1)
    );

    timer_ctrl #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .halt(halt), .clr(clr),
        .mtimecmp(mtimecmp), .msip(msip),
        .mtime(m4), .tick(t4), .mtip(p4), .msip_irq(i4)
    );

    timer_ctrl #(.PRESCALE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .halt(halt), .clr(clr),
        .mtimecmp(mtimecmp), .msip(msip),
        .mtime(m8), .tick(t8), .mtip(p8), .msip_irq(i8)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        halt     = 1'b0;
        clr      = 1'b0;
        mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
        msip     = 32'h0000_0000;
        step(2);

        // Reset state
        check("rst_mtime1", m1, 64'd0);
        check("rst_mtime8", m8, 64'd0);
        check("rst_tick4", {63'd0, t4}, 64'd0);
        check("rst_mtip1", {63'd0, p1}, 64'd0);
        check("rst_irq1", {63'd0, i1}, 64'd0);

        // Prescale: PRESCALE=4 ticks on every 4th edge, mtip stays low
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            check($sformatf("ps_tick4_%0d", i), {63'd0, t4}, {63'd0, (i % 4) == 0});
            check($sformatf("ps_mtip4_%0d", i), {63'd0, p4}, 64'd0);
        end
        en = 1'b0;
        step(1);
        check("ps_mtime4", m4, 64'd10);
        check("ps_mtime1", m1, 64'd40);
        check("ps_mtime8", m8, 64'd5);

        // Carry across the low-half wrap with a coherent snapshot
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("carry_clr", m1, 64'd0);
        force dut1.lo_d = 32'hFFFF_FFFE;
        force dut1.hi_d = 32'h0000_0000;
        step(1);
        release dut1.lo_d;
        release dut1.hi_d;
        step(1);
        check("carry_preload", m1, 64'h0000_0000_FFFF_FFFE);
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check($sformatf("carry_seq_%0d", k), m1, carry_seq[k]);
        end
        en = 1'b0;

        // Compare: mtip rises 2 edges after mtime reaches mtimecmp, falls 2 after rewrite
        mtimecmp = 64'h0000_0001_0000_0005;
        force dut1.lo_d = 32'h0000_0000;
        force dut1.hi_d = 32'h0000_0001;
        step(1);
        release dut1.lo_d;
        release dut1.hi_d;
        step(1);
        check("cmp_preload", m1, 64'h0000_0001_0000_0000);
        check("cmp_mtip_low", {63'd0, p1}, 64'd0);
        en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            check($sformatf("cmp_mtime_%0d", k), m1, 64'h0000_0001_0000_0000 + 64'(k - 1));
            check($sformatf("cmp_mtip_%0d", k), {63'd0, p1}, {63'd0, k >= 8});
        end
        en       = 1'b0;
        mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1);
        check("cmp_drop_1", {63'd0, p1}, 64'd1);
        step(1);
        check("cmp_drop_2", {63'd0, p1}, 64'd0);

        // Halt mid-prescale on PRESCALE=8: resumes from held count
        clr = 1'b1;
        en  = 1'b1;
        step(1);
        clr = 1'b0;
        check("halt_clr", m8, 64'd0);
        step(13);
        check("halt_pre", m8, 64'd1);
        halt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            check($sformatf("halt_mtime_%0d", k), m8, 64'd1);
            check($sformatf("halt_tick_%0d", k), {63'd0, t8}, 64'd0);
        end
        halt = 1'b0;
        step(1);
        check("resume_tick_1", {63'd0, t8}, 64'd0);
        step(1);
        check("resume_tick_2", {63'd0, t8}, 64'd0);
        step(1);
        check("resume_tick_3", {63'd0, t8}, 64'd1);
        check("resume_mtime_3", m8, 64'd1);
        step(1);
        check("resume_tick_4", {63'd0, t8}, 64'd0);
        check("resume_mtime_4", m8, 64'd2);

        // Clear during a pending carry
        en       = 1'b0;
        mtimecmp = 64'h0000_0000_FFFF_FFF0;
        force dut1.lo_d = 32'hFFFF_FFFF;
        force dut1.hi_d = 32'h0000_0000;
        step(1);
        release dut1.lo_d;
        release dut1.hi_d;
        step(3);
        check("clr_preload", m1, 64'h0000_0000_FFFF_FFFF);
        check("clr_mtip_pre", {63'd0, p1}, 64'd1);
        en = 1'b1;
        step(1);
        check("clr_carry_hold", m1, 64'h0000_0000_FFFF_FFFF);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr_mtime", m1, 64'd0);
        check("clr_tick", {63'd0, t1}, 64'd0);
        check("clr_mtip_1", {63'd0, p1}, 64'd1);
        step(1);
        check("clr_mtime_2", m1, 64'd0);
        check("clr_mtip_2", {63'd0, p1}, 64'd1);
        step(1);
        check("clr_mtime_3", m1, 64'd1);
        check("clr_mtip_3", {63'd0, p1}, 64'd0);
        step(1);
        check("clr_no_late_carry", m1, 64'd2);

        // Software interrupt: only bit 0 matters, one cycle latency
        en   = 1'b0;
        msip = 32'h0000_0002;
        step(1);
        check("msip_bit1", {63'd0, i1}, 64'd0);
        msip = 32'h0000_0001;
        #1;
        check("msip_latency", {63'd0, i1}, 64'd0);
        step(1);
        check("msip_bit0", {63'd0, i1}, 64'd1);

        // Reset mid-count clears every output on the next edge
        mtimecmp = 64'd0;
        en       = 1'b1;
        step(3);
        check("prerst_tick1", {63'd0, t1}, 64'd1);
        check("prerst_mtip1", {63'd0, p1}, 64'd1);
        rst_n = 1'b0;
        step(1);
        check("rst2_mtime1", m1, 64'd0);
        check("rst2_mtime4", m4, 64'd0);
        check("rst2_mtime8", m8, 64'd0);
        check("rst2_outs1", {60'd0, t1, p1, i1}, 64'd0);
        check("rst2_outs4", {60'd0, t4, p4, i4}, 64'd0);
        check("rst2_outs8", {60'd0, t8, p8, i8}, 64'd0);
        rst_n = 1'b1;
        en    = 1'b0;
        msip  = 32'h0000_0000;
        step(1);
        check("postrst_mtip_1", {63'd0, p1}, 64'd0);
        step(1);
        check("postrst_mtip_2", {63'd0, p1}, 64'd1);
        check("postrst_mtime", m1, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
